// File: rtl/axi4_stream_hdr_pkg.sv
// Shared types and the per-lane first-beat merge rule for the header merge block.
package axi4_stream_hdr_pkg;

  typedef enum logic {FIRST, BODY} hdr_merge_state_t;

  // One byte lane after merging; hit flags a header lane that already carried data.
  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       strb;
    logic       hit;
  } lane_beat_t;

  function automatic lane_beat_t merge_first_beat(
    input logic [7:0]  data,
    input logic        keep,
    input logic        strb,
    input logic [7:0]  hdr,
    input int unsigned len,
    input int unsigned lane
  );
    lane_beat_t r;
    r.hit = 1'b0;
    if (lane < len) begin
      r.data = hdr;
      r.keep = 1'b1;
      r.strb = 1'b1;
      r.hit  = keep | strb;
    end else begin
      r.data = data;
      r.keep = keep;
      r.strb = strb;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  localparam int DATA_WIDTH_B = DATA_WIDTH / 8;

  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH_B-1:0] tkeep;
  logic [DATA_WIDTH_B-1:0] tstrb;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tlast;

  modport master (output tvalid, tdata, tkeep, tstrb, tid, tdest, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tstrb, tid, tdest, tuser, tlast, output tready);
endinterface

// File: rtl/axi4_stream_skid_buf.sv
// Two-entry register slice on a full AXI4-Stream beat; in_ready is a flop so the
// upstream never sees out_ready combinationally.
module axi4_stream_skid_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  localparam int BEAT_W    = DATA_WIDTH + 2 * (DATA_WIDTH / 8) + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_beat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_beat
);

  logic [BEAT_W-1:0] skid_q;
  logic              skid_vld_q, skid_vld_d;
  logic              room_q;
  logic              push, load_out;

  assign push     = in_valid && room_q;
  assign load_out = !out_valid || out_ready;
  assign in_ready = room_q;

  // Room exists only when the spare entry will be empty after this edge.
  always_comb begin
    skid_vld_d = skid_vld_q;
    if (load_out)  skid_vld_d = 1'b0;
    else if (push) skid_vld_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      room_q     <= 1'b1;
    end else begin
      skid_vld_q <= skid_vld_d;
      room_q     <= !skid_vld_d;
      if (load_out) begin
        if (skid_vld_q) begin
          out_valid <= 1'b1;
          out_beat  <= skid_q;
        end else begin
          out_valid <= push;
          if (push) out_beat <= in_beat;
        end
      end else if (push) begin
        skid_q <= in_beat;
      end
    end
  end

endmodule

// File: rtl/axi4_stream_header_merge.sv
// Fills the vacated low lanes of each packet's first beat with a separately
// handshaken header word; output registered through a two-entry skid buffer.
module axi4_stream_header_merge
  import axi4_stream_hdr_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int DATA_WIDTH_B   = DATA_WIDTH / 8,
  parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH-1:0]     hdr_i,
  input  logic [DATA_WIDTH_B_W-1:0] hdr_len_i,
  input  logic                      hdr_valid_i,
  output logic                      hdr_ready_o,
  output logic                      collision_o,
  axi4_stream_if.slave              pkt_i,
  axi4_stream_if.master             pkt_o
);

  localparam int BEAT_W = DATA_WIDTH + 2 * DATA_WIDTH_B + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

  hdr_merge_state_t          state_q, state_d;
  logic                      hdr_held_q;
  logic [DATA_WIDTH-1:0]     hdr_q;
  logic [DATA_WIDTH_B_W-1:0] len_q;
  logic                      collision_q;

  logic                      skid_room;
  logic                      in_fire, first;
  logic [DATA_WIDTH-1:0]     mrg_data;
  logic [DATA_WIDTH_B-1:0]   mrg_keep, mrg_strb, hit;
  logic [BEAT_W-1:0]         in_beat, out_beat;

  assign first        = (state_q == FIRST);
  // A first beat never bypasses the header register, so it waits for hdr_held.
  assign pkt_i.tready = skid_room && (!first || hdr_held_q);
  assign in_fire      = pkt_i.tvalid && pkt_i.tready;
  assign hdr_ready_o  = !hdr_held_q;
  assign collision_o  = collision_q;

  for (genvar i = 0; i < DATA_WIDTH_B; i++) begin : g_lane
    lane_beat_t m;
    assign m = merge_first_beat(pkt_i.tdata[i*8 +: 8], pkt_i.tkeep[i], pkt_i.tstrb[i],
                                hdr_q[i*8 +: 8], 32'(len_q), 32'(i));
    assign mrg_data[i*8 +: 8] = first ? m.data : pkt_i.tdata[i*8 +: 8];
    assign mrg_keep[i]        = first ? m.keep : pkt_i.tkeep[i];
    assign mrg_strb[i]        = first ? m.strb : pkt_i.tstrb[i];
    assign hit[i]             = m.hit;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FIRST: if (in_fire && !pkt_i.tlast) state_d = BODY;
      BODY:  if (in_fire &&  pkt_i.tlast) state_d = FIRST;
    endcase
  end

  // Header capture and first-beat consumption are mutually exclusive: the
  // first beat is only accepted while a header is already held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FIRST;
      hdr_held_q  <= 1'b0;
      hdr_q       <= '0;
      len_q       <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      collision_q <= in_fire && first && (|hit);
      if (hdr_valid_i && !hdr_held_q) begin
        hdr_q      <= hdr_i;
        len_q      <= hdr_len_i;
        hdr_held_q <= 1'b1;
      end else if (in_fire && first) begin
        hdr_held_q <= 1'b0;
      end
    end
  end

  assign in_beat = {mrg_data, mrg_keep, mrg_strb, pkt_i.tid, pkt_i.tdest, pkt_i.tuser, pkt_i.tlast};

  axi4_stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .DEST_WIDTH (DEST_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (pkt_i.tvalid && (!first || hdr_held_q)),
    .in_ready  (skid_room),
    .in_beat   (in_beat),
    .out_valid (pkt_o.tvalid),
    .out_ready (pkt_o.tready),
    .out_beat  (out_beat)
  );

  assign {pkt_o.tdata, pkt_o.tkeep, pkt_o.tstrb, pkt_o.tid, pkt_o.tdest, pkt_o.tuser, pkt_o.tlast} = out_beat;

endmodule

// File: tb/tb_axi4_stream_header_merge.sv
// Directed and randomized checks of the header merge against a mask-arithmetic model.
module tb_axi4_stream_header_merge;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  s;
    logic        id;
    logic        dest;
    logic        user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] hdr_i = '0;
  logic [1:0]  hdr_len_i = '0;
  logic        hdr_valid_i = 1'b0;
  logic        hdr_ready_o, collision_o;

  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) pkt_in ();
  axi4_stream_if #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) pkt_out ();

  axi4_stream_header_merge dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .hdr_i       (hdr_i),
    .hdr_len_i   (hdr_len_i),
    .hdr_valid_i (hdr_valid_i),
    .hdr_ready_o (hdr_ready_o),
    .collision_o (collision_o),
    .pkt_i       (pkt_in),
    .pkt_o       (pkt_out)
  );

  int    errors = 0, checks = 0;
  int    n_coll = 0, exp_coll = 0;
  int    rdy_mode = 0;
  beat_t exp_q[$], obs_q[$];
  beat_t cur, held;
  logic  stall_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Header lanes are the low len bytes: mask them in with plain arithmetic.
  function automatic beat_t model_first(input beat_t b, input logic [31:0] h, input int len);
    logic [31:0] bm;
    logic [3:0]  lm;
    beat_t       r;
    bm  = 32'((64'(1) << (8 * len)) - 64'(1));
    lm  = 4'((1 << len) - 1);
    r   = b;
    r.d = (b.d & ~bm) | (h & bm);
    r.k = b.k | lm;
    r.s = b.s | lm;
    return r;
  endfunction

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic last);
    beat_t r;
    r = '0;
    r.d = d; r.k = k; r.s = k; r.last = last;
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    pkt_out.tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Output monitor: scoreboard, stall stability, collision pulse count.
  always @(negedge clk) begin
    cur = {pkt_out.tdata, pkt_out.tkeep, pkt_out.tstrb, pkt_out.tid, pkt_out.tdest, pkt_out.tuser, pkt_out.tlast};
    if (rst_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stable_while_stalled", cur, held);
      if (pkt_out.tvalid && pkt_out.tready) begin
        chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("beat", cur, exp_q.pop_front());
        obs_q.push_back(cur);
      end
      if (collision_o) n_coll++;
      stall_prev = pkt_out.tvalid && !pkt_out.tready;
      held = cur;
    end
  end

  task automatic send_hdr(input logic [31:0] h, input int len);
    int   n = 0;
    logic ok = 1'b0;
    hdr_i = h; hdr_len_i = 2'(len); hdr_valid_i = 1'b1;
    while (!ok && n < 500) begin
      @(negedge clk); ok = hdr_ready_o; n++;
      @(posedge clk); #1;
    end
    chk("hdr_handshake", 64'(ok), 64'd1);
    hdr_valid_i = 1'b0;
  endtask

  task automatic send_beat(input beat_t b);
    int   n = 0;
    logic ok = 1'b0;
    {pkt_in.tdata, pkt_in.tkeep, pkt_in.tstrb, pkt_in.tid, pkt_in.tdest, pkt_in.tuser, pkt_in.tlast} = b;
    pkt_in.tvalid = 1'b1;
    while (!ok && n < 500) begin
      @(negedge clk); ok = pkt_in.tready; n++;
      @(posedge clk); #1;
    end
    chk("beat_handshake", 64'(ok), 64'd1);
    pkt_in.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] h, input int len, input beat_t pk[$], input logic gaps);
    send_hdr(h, len);
    for (int i = 0; i < pk.size(); i++) begin
      if (i == 0) begin
        exp_q.push_back(model_first(pk[0], h, len));
        if (((pk[0].k | pk[0].s) & 4'((1 << len) - 1)) != 4'd0) exp_coll++;
      end else begin
        exp_q.push_back(pk[i]);
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_beat(pk[i]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(posedge clk); n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t pk[$];
    beat_t b;
    int    c0, e0, nb;

    pkt_in.tvalid = 1'b0; pkt_in.tdata = '0; pkt_in.tkeep = '0; pkt_in.tstrb = '0;
    pkt_in.tid = '0; pkt_in.tdest = '0; pkt_in.tuser = '0; pkt_in.tlast = 1'b0;
    pkt_out.tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(pkt_out.tvalid), 64'd0);
    chk("rst_tdata", 64'(pkt_out.tdata), 64'd0);
    chk("rst_tkeep", 64'(pkt_out.tkeep), 64'd0);
    chk("rst_tlast", 64'(pkt_out.tlast), 64'd0);
    chk("rst_hdr_ready", 64'(hdr_ready_o), 64'd1);
    chk("rst_collision", 64'(collision_o), 64'd0);
    chk("rst_in_tready", 64'(pkt_in.tready), 64'd0);
    @(posedge clk); #1 rst_i = 1'b0;

    // Three-beat packet, one header byte
    obs_q.delete(); c0 = n_coll;
    pk = '{mk(32'h11223300, 4'b1110, 1'b0), mk(32'h55667788, 4'hF, 1'b0), mk(32'h99AABBCC, 4'hF, 1'b1)};
    send_pkt(32'hAABBCCDD, 1, pk, 1'b0);
    drain();
    chk("t1_count", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() == 3) begin
      chk("t1_first_data", 64'(obs_q[0].d), 64'h112233DD);
      chk("t1_first_keep", 64'(obs_q[0].k), 64'hF);
      chk("t1_beat2", 64'(obs_q[1].d), 64'h55667788);
      chk("t1_beat3_last", 64'(obs_q[2].last), 64'd1);
    end
    chk("t1_no_collision", 64'(n_coll - c0), 64'd0);

    // First beat stalls until a header arrives
    obs_q.delete();
    b = mk(32'hCAFEF00D, 4'hF, 1'b1);
    exp_q.push_back(model_first(b, 32'h01020304, 2));
    exp_coll++;
    {pkt_in.tdata, pkt_in.tkeep, pkt_in.tstrb, pkt_in.tid, pkt_in.tdest, pkt_in.tuser, pkt_in.tlast} = b;
    pkt_in.tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_stall_no_hdr", 64'(pkt_in.tready), 64'd0);
      @(posedge clk); #1;
    end
    hdr_i = 32'h01020304; hdr_len_i = 2'd2; hdr_valid_i = 1'b1;
    @(negedge clk);
    chk("t2_hdr_ready", 64'(hdr_ready_o), 64'd1);
    chk("t2_still_stalled", 64'(pkt_in.tready), 64'd0);
    @(posedge clk); #1 hdr_valid_i = 1'b0;
    @(negedge clk);
    chk("t2_accept_next_cycle", 64'(pkt_in.tready), 64'd1);
    chk("t2_out_not_yet", 64'(pkt_out.tvalid), 64'd0);
    @(posedge clk); #1 pkt_in.tvalid = 1'b0;
    @(negedge clk);
    chk("t2_out_valid", 64'(pkt_out.tvalid), 64'd1);
    drain();
    if (obs_q.size() == 1) chk("t2_data", 64'(obs_q[0].d), 64'hCAFE0304);

    // Single-beat packet, two header bytes into empty lanes
    obs_q.delete(); c0 = n_coll;
    pk = '{mk(32'h12340000, 4'b1100, 1'b1)};
    send_pkt(32'h0BADBEEF, 2, pk, 1'b0);
    drain();
    chk("t3_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) begin
      chk("t3_data", 64'(obs_q[0].d), 64'h1234BEEF);
      chk("t3_keep", 64'(obs_q[0].k), 64'hF);
      chk("t3_last", 64'(obs_q[0].last), 64'd1);
    end
    chk("t3_back_to_first", 64'(pkt_in.tready), 64'd0);
    chk("t3_hdr_ready", 64'(hdr_ready_o), 64'd1);
    chk("t3_no_collision", 64'(n_coll - c0), 64'd0);

    // Collision: header lanes already occupied
    obs_q.delete(); c0 = n_coll;
    pk = '{mk(32'hFFFFFFFF, 4'hF, 1'b0), mk(32'h00000000, 4'hF, 1'b1)};
    send_pkt(32'h44332211, 2, pk, 1'b0);
    drain();
    chk("t4_collision_once", 64'(n_coll - c0), 64'd1);
    if (obs_q.size() == 2) chk("t4_data", 64'(obs_q[0].d), 64'hFFFF2211);

    // Randomized traffic with 50% output backpressure
    rdy_mode = 1; obs_q.delete(); c0 = n_coll; e0 = exp_coll; nb = 0;
    for (int p = 0; p < 100; p++) begin
      int len, nbeats;
      len = $urandom_range(0, 3);
      nbeats = $urandom_range(1, 5);
      pk.delete();
      for (int j = 0; j < nbeats; j++) begin
        b = mk($urandom, 4'($urandom), 1'(j == nbeats - 1));
        b.s = 4'($urandom) & b.k;
        b.id = 1'($urandom); b.dest = 1'($urandom); b.user = 1'($urandom);
        pk.push_back(b);
      end
      nb += nbeats;
      send_pkt($urandom, len, pk, 1'b1);
      chk("rand_hdr_consumed", 64'(hdr_ready_o), 64'd1);
    end
    drain();
    chk("rand_beat_count", 64'(obs_q.size()), 64'(nb));
    chk("rand_collisions", 64'(n_coll - c0), 64'(exp_coll - e0));

    // Reset during beat 2 of a 4-beat packet
    rdy_mode = 2;
    send_hdr(32'h55555555, 1);
    send_beat(mk(32'hAAAAAA00, 4'b1110, 1'b0));
    b = mk(32'hBBBBBBBB, 4'hF, 1'b0);
    {pkt_in.tdata, pkt_in.tkeep, pkt_in.tstrb, pkt_in.tid, pkt_in.tdest, pkt_in.tuser, pkt_in.tlast} = b;
    pkt_in.tvalid = 1'b1;
    @(negedge clk);
    chk("t6_out_valid_before", 64'(pkt_out.tvalid), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_tvalid", 64'(pkt_out.tvalid), 64'd0);
    chk("t6_rst_hdr_ready", 64'(hdr_ready_o), 64'd1);
    pkt_in.tvalid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst_i = 1'b0; rdy_mode = 0;
    obs_q.delete();
    pk = '{mk(32'h12000000, 4'b1000, 1'b0), mk(32'h0000ABCD, 4'b0011, 1'b1)};
    send_pkt(32'h66778899, 3, pk, 1'b0);
    drain();
    chk("t6_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      chk("t6_first_merged", 64'(obs_q[0].d), 64'h12778899);
      chk("t6_first_keep", 64'(obs_q[0].k), 64'hF);
      chk("t6_second", 64'(obs_q[1].d), 64'h0000ABCD);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
